round_resolver: RTL and testbench

- Consumer end of the choice-validation path.
- Takes the validated one-hot final choices of player and computer, resolves one standoff round, and maintains both bullet counts.
- Those counts feed back as the `count` inputs of the two validators.
- Sequences rounds: accept, resolve, hold for display, then wait for the next round or stop at game over.

---
 rtl/standoff_pkg.sv | 49 ++++
 rtl/duel_rules.sv | 51 +++++
 rtl/round_resolver.sv | 165 ++++++++++++++++
 tb/tb_round_resolver.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/standoff_pkg.sv
// standoff_pkg
// Shared encodings for the standoff round resolver: one-hot choice codes,
// outcome codes, the resolver state enum and the per-side action decode.
package standoff_pkg;

  localparam logic [3:0] CH_SHOOT  = 4'b0100;
  localparam logic [3:0] CH_RELOAD = 4'b0010;
  localparam logic [3:0] CH_DUCK   = 4'b0001;
  localparam logic [3:0] CH_IDLE   = 4'b1000;

  localparam logic [1:0] OUT_NONE  = 2'b00;
  localparam logic [1:0] OUT_P_WIN = 2'b01;
  localparam logic [1:0] OUT_C_WIN = 2'b10;
  localparam logic [1:0] OUT_DRAW  = 2'b11;

  localparam logic [1:0] MAX_BULLETS = 2'd3;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_RESOLVE = 2'd1,
    S_HOLD    = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ACT_IDLE   = 2'd0,
    ACT_SHOOT  = 2'd1,
    ACT_RELOAD = 2'd2,
    ACT_DUCK   = 2'd3
  } action_t;

  // Effective action of one side. Actions that cannot take effect (shoot
  // with an empty gun, reload with a full one, malformed codes) collapse
  // to idle so the outcome table only has to reason about real actions.
  function automatic action_t decode_action(input logic [3:0] ch,
                                            input logic [1:0] cnt);
    action_t act;
    act = ACT_IDLE;
    case (ch)
      CH_SHOOT:  act = (cnt != 2'd0)        ? ACT_SHOOT  : ACT_IDLE;
      CH_RELOAD: act = (cnt != MAX_BULLETS) ? ACT_RELOAD : ACT_IDLE;
      CH_DUCK:   act = ACT_DUCK;
      CH_IDLE:   act = ACT_IDLE;
      default:   act = ACT_IDLE;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/duel_rules.sv
// duel_rules
// Purely combinational round rules: maps both final choices and both
// current bullet counts to the next counts and the raw outcome.
// Ports:
//   i_p_choice, i_c_choice : one-hot choices (player / computer)
//   i_p_count,  i_c_count  : bullet counts before the round
//   o_p_count,  o_c_count  : bullet counts after the round
//   o_outcome              : OUT_NONE / OUT_P_WIN / OUT_C_WIN
module duel_rules
  import standoff_pkg::*;
(
  input  logic [3:0] i_p_choice,
  input  logic [3:0] i_c_choice,
  input  logic [1:0] i_p_count,
  input  logic [1:0] i_c_count,
  output logic [1:0] o_p_count,
  output logic [1:0] o_c_count,
  output logic [1:0] o_outcome
);

  action_t w_p_act;
  action_t w_c_act;

  always_comb begin
    w_p_act = decode_action(i_p_choice, i_p_count);
    w_c_act = decode_action(i_c_choice, i_c_count);
  end

  // decode_action already guarantees shoot only with count>0 and reload
  // only with count<3, so no saturation checks are needed here.
  always_comb begin
    o_p_count = i_p_count;
    o_c_count = i_c_count;
    if (w_p_act == ACT_SHOOT)  o_p_count = i_p_count - 2'd1;
    if (w_p_act == ACT_RELOAD) o_p_count = i_p_count + 2'd1;
    if (w_c_act == ACT_SHOOT)  o_c_count = i_c_count - 2'd1;
    if (w_c_act == ACT_RELOAD) o_c_count = i_c_count + 2'd1;
  end

  // A shot only lands on an opponent who is reloading or idle.
  always_comb begin
    o_outcome = OUT_NONE;
    if (w_p_act == ACT_SHOOT &&
        (w_c_act == ACT_RELOAD || w_c_act == ACT_IDLE))
      o_outcome = OUT_P_WIN;
    else if (w_c_act == ACT_SHOOT &&
             (w_p_act == ACT_RELOAD || w_p_act == ACT_IDLE))
      o_outcome = OUT_C_WIN;
  end

endmodule

// File: rtl/round_resolver.sv
// round_resolver
// Consumer end of the choice-validation path: accepts the validated final
// choices of both sides, resolves one standoff round, keeps both bullet
// counts and sequences rounds (accept, resolve, hold, wait / game over).
// Optional feature macro: ROUND_LIMIT_EN (round limit of MAX_ROUNDS ends the
// game in a draw). Default build: no limit, outcome 11 never produced.
// Ports:
//   clk, rst          : clock (rising edge), async active-high reset
//   p_choice/c_choice : one-hot final choices
//   choice_valid      : both choices present (taken only while ready=1)
//   new_game          : restart pulse, highest priority
//   ready             : high in S_WAIT only
//   p_count/c_count   : bullet counts, fed back to the validators
//   outcome           : 00 continue, 01 player wins, 10 computer wins, 11 draw
//   result_valid      : one-cycle pulse when outcome/counts update
//   game_over         : high in S_OVER
//   round_num         : completed rounds, saturating
//
// state     | meaning
// S_WAIT    | idle, ready=1, waiting for choice_valid
// S_RESOLVE | choices latched, counts/outcome update at the next edge
// S_HOLD    | result held for HOLD_CYCLES cycles
// S_OVER    | game finished, outputs frozen until new_game
module round_resolver
  import standoff_pkg::*;
#(
  parameter int START_BULLETS = 1,
  parameter int HOLD_CYCLES   = 4,
  parameter int ROUND_W       = 8,
  parameter int MAX_ROUNDS    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         p_choice,
  input  logic [3:0]         c_choice,
  input  logic               choice_valid,
  input  logic               new_game,
  output logic               ready,
  output logic [1:0]         p_count,
  output logic [1:0]         c_count,
  output logic [1:0]         outcome,
  output logic               result_valid,
  output logic               game_over,
  output logic [ROUND_W-1:0] round_num
);

  localparam logic [1:0] START_CNT = 2'(START_BULLETS);
  localparam int         HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef ROUND_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_p_ch;
  logic [3:0]           r_c_ch;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [1:0]           r_p_count;
  logic [1:0]           r_c_count;
  logic [1:0]           r_outcome;
  logic                 r_result_valid;
  logic                 r_game_over;
  logic [ROUND_W-1:0]   r_round_num;

  logic [1:0]           w_p_next;
  logic [1:0]           w_c_next;
  logic [1:0]           w_raw_outcome;
  logic [1:0]           w_final_outcome;
  logic [ROUND_W-1:0]   w_round_inc;
  logic                 w_limit_hit;

  duel_rules u_rules (
    .i_p_choice (r_p_ch),
    .i_c_choice (r_c_ch),
    .i_p_count  (r_p_count),
    .i_c_count  (r_c_count),
    .o_p_count  (w_p_next),
    .o_c_count  (w_c_next),
    .o_outcome  (w_raw_outcome)
  );

  always_comb begin
    w_round_inc = (r_round_num == {ROUND_W{1'b1}}) ? r_round_num
                                                    : r_round_num + 1'b1;
    // Limit only turns an undecided round into a draw; a real win stands.
    w_limit_hit = LIMIT_EN && (w_raw_outcome == OUT_NONE) &&
                  (w_round_inc >= ROUND_W'(MAX_ROUNDS));
    w_final_outcome = w_limit_hit ? OUT_DRAW : w_raw_outcome;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_WAIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (new_game) begin
      w_state_nxt = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT:    if (choice_valid) w_state_nxt = S_RESOLVE;
        S_RESOLVE: w_state_nxt = (w_final_outcome != OUT_NONE) ? S_OVER : S_HOLD;
        S_HOLD:    if (r_hold_cnt == '0) w_state_nxt = S_WAIT;
        S_OVER:    w_state_nxt = S_OVER;
        default:   w_state_nxt = S_WAIT;
      endcase
    end
  end

  // Hold timer: loaded while resolving, terminal count ends the hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (r_state == S_RESOLVE) begin
      r_hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
    end else if (r_state == S_HOLD && r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_ch         <= CH_IDLE;
      r_c_ch         <= CH_IDLE;
      r_p_count      <= START_CNT;
      r_c_count      <= START_CNT;
      r_outcome      <= OUT_NONE;
      r_result_valid <= 1'b0;
      r_game_over    <= 1'b0;
      r_round_num    <= '0;
    end else begin
      r_result_valid <= 1'b0;
      if (new_game) begin
        r_p_count   <= START_CNT;
        r_c_count   <= START_CNT;
        r_outcome   <= OUT_NONE;
        r_game_over <= 1'b0;
        r_round_num <= '0;
      end else if (r_state == S_WAIT && choice_valid) begin
        r_p_ch <= p_choice;
        r_c_ch <= c_choice;
      end else if (r_state == S_RESOLVE) begin
        r_p_count      <= w_p_next;
        r_c_count      <= w_c_next;
        r_outcome      <= w_final_outcome;
        r_round_num    <= w_round_inc;
        r_result_valid <= 1'b1;
        r_game_over    <= (w_final_outcome != OUT_NONE);
      end
    end
  end

  assign ready        = (r_state == S_WAIT);
  assign p_count      = r_p_count;
  assign c_count      = r_c_count;
  assign outcome      = r_outcome;
  assign result_valid = r_result_valid;
  assign game_over    = r_game_over;
  assign round_num    = r_round_num;

endmodule

// File: tb/tb_round_resolver.sv
module tb_round_resolver;

  localparam int START = 1;
  localparam int HOLD  = 4;
  localparam int RW    = 8;
  localparam int MAXR  = 3;

  localparam logic [3:0] SHOOT  = 4'b0100;
  localparam logic [3:0] RELOAD = 4'b0010;
  localparam logic [3:0] DUCK   = 4'b0001;
  localparam logic [3:0] IDLE   = 4'b1000;

  logic          clk;
  logic          rst;
  logic [3:0]    p_choice;
  logic [3:0]    c_choice;
  logic          choice_valid;
  logic          new_game;
  logic          ready;
  logic [1:0]    p_count;
  logic [1:0]    c_count;
  logic [1:0]    outcome;
  logic          result_valid;
  logic          game_over;
  logic [RW-1:0] round_num;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  round_resolver #(
    .START_BULLETS(START), .HOLD_CYCLES(HOLD), .ROUND_W(RW), .MAX_ROUNDS(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .p_choice(p_choice), .c_choice(c_choice),
    .choice_valid(choice_valid), .new_game(new_game), .ready(ready),
    .p_count(p_count), .c_count(c_count), .outcome(outcome),
    .result_valid(result_valid), .game_over(game_over), .round_num(round_num)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game quantities plus a "busy" cycle budget.
  int         m_p = START, m_c = START, m_out = 0, m_round = 0, m_wait = 0;
  bit         m_over = 0, m_pend = 0, m_rv = 0;
  logic [3:0] m_pch = IDLE, m_cch = IDLE;

  task automatic model_resolve();
    bit ps, pr, pd, cs, cr, cd;
    ps = (m_pch == SHOOT) && (m_p > 0);
    pr = (m_pch == RELOAD) && (m_p < 3);
    pd = (m_pch == DUCK);
    cs = (m_cch == SHOOT) && (m_c > 0);
    cr = (m_cch == RELOAD) && (m_c < 3);
    cd = (m_cch == DUCK);
    m_p = m_p - int'(ps) + int'(pr);
    m_c = m_c - int'(cs) + int'(cr);
    if (ps && !cs && !cd)      m_out = 1;
    else if (cs && !ps && !pd) m_out = 2;
    else                       m_out = 0;
    if (m_round < 255) m_round++;
`ifdef ROUND_LIMIT_EN
    if (m_out == 0 && m_round >= MAXR) m_out = 3;
`endif
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p = START; m_c = START; m_out = 0; m_round = 0;
      m_over = 0; m_pend = 0; m_rv = 0; m_wait = 0;
    end else begin
      m_rv = 0;
      if (new_game) begin
        m_p = START; m_c = START; m_out = 0; m_round = 0;
        m_over = 0; m_pend = 0; m_wait = 0;
      end else if (m_pend) begin
        model_resolve();
        m_pend = 0;
        m_rv = 1;
        if (m_out != 0) m_over = 1;
        else            m_wait = HOLD;
      end else if (m_over) begin
        m_over = 1;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (choice_valid) begin
        m_pch = p_choice;
        m_cch = c_choice;
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_ready", int'(ready), int'(!m_over && !m_pend && m_wait == 0));
      check("cmp_p_count", int'(p_count), m_p);
      check("cmp_c_count", int'(c_count), m_c);
      check("cmp_outcome", int'(outcome), m_out);
      check("cmp_result_valid", int'(result_valid), int'(m_rv));
      check("cmp_game_over", int'(game_over), int'(m_over));
      check("cmp_round_num", int'(round_num), m_round);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", int'(ready), 1);
  endtask

  // Returns at the negedge after the resolving edge (result_valid high).
  task automatic do_round(input logic [3:0] p, input logic [3:0] c);
    wait_ready();
    p_choice = p; c_choice = c; choice_valid = 1;
    @(negedge clk);
    choice_valid = 0;
    @(negedge clk);
  endtask

  task automatic pulse_new_game();
    new_game = 1;
    @(negedge clk);
    new_game = 0;
  endtask

  function automatic logic [3:0] pick();
    int r;
    logic [3:0] v;
    r = $urandom_range(0, 9);
    if (r < 3)      v = SHOOT;
    else if (r < 5) v = RELOAD;
    else if (r < 7) v = DUCK;
    else if (r < 8) v = IDLE;
    else            v = 4'($urandom_range(0, 15));
    return v;
  endfunction

  int lows;

  initial begin
    rst = 1; new_game = 0; choice_valid = 0; p_choice = IDLE; c_choice = IDLE;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_p_count", int'(p_count), 1);
    check("rst_c_count", int'(c_count), 1);
    check("rst_ready", int'(ready), 1);
    check("rst_outcome", int'(outcome), 0);
    check("rst_round", int'(round_num), 0);
    rst = 0;
    @(negedge clk);

    // 1: reload vs duck, one-cycle result pulse, ready low window
    do_round(RELOAD, DUCK);
    check("t1_p_count", int'(p_count), 2);
    check("t1_c_count", int'(c_count), 1);
    check("t1_outcome", int'(outcome), 0);
    check("t1_rv", int'(result_valid), 1);
    check("t1_ready_low", int'(ready), 0);
    lows = 2;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) check("t1_rv_pulse", int'(result_valid), 0);
      if (ready) break;
      lows++;
    end
    check("t1_accept_spacing", lows + 1, HOLD + 2);

    // 2: player shoot vs reload wins; game over ignores further choices
    pulse_new_game();
    do_round(SHOOT, RELOAD);
    check("t2_outcome", int'(outcome), 1);
    check("t2_p_count", int'(p_count), 0);
    check("t2_c_count", int'(c_count), 2);
    check("t2_game_over", int'(game_over), 1);
    p_choice = RELOAD; c_choice = SHOOT; choice_valid = 1;
    repeat (4) @(negedge clk);
    choice_valid = 0;
    check("t2_over_ready", int'(ready), 0);
    check("t2_over_c_count", int'(c_count), 2);
    check("t2_over_round", int'(round_num), 1);

    // 3: shoot vs shoot, then duck vs shoot
    pulse_new_game();
    check("t3_ng_p_count", int'(p_count), 1);
    check("t3_ng_go", int'(game_over), 0);
    do_round(RELOAD, RELOAD);
    do_round(SHOOT, SHOOT);
    check("t3_ss_p", int'(p_count), 1);
    check("t3_ss_c", int'(c_count), 1);
    check("t3_ss_out", int'(outcome), 0);
    pulse_new_game();
    do_round(DUCK, SHOOT);
    check("t3_ds_c", int'(c_count), 0);
    check("t3_ds_p", int'(p_count), 1);
    check("t3_ds_out", int'(outcome), 0);

    // 4: reload saturation; empty shoot acts as idle
    pulse_new_game();
    do_round(RELOAD, RELOAD);
    do_round(RELOAD, RELOAD);
    check("t4_p_three", int'(p_count), 3);
    pulse_new_game();
    do_round(RELOAD, RELOAD);
    do_round(RELOAD, RELOAD);
    pulse_new_game();
    do_round(SHOOT, DUCK);
    check("t4_p_empty", int'(p_count), 0);
    check("t4_c_one", int'(c_count), 1);
    do_round(SHOOT, SHOOT);
    check("t4_c_wins", int'(outcome), 2);
    check("t4_p_stays0", int'(p_count), 0);
    check("t4_c_zero", int'(c_count), 0);
    pulse_new_game();
    do_round(RELOAD, RELOAD);
    do_round(RELOAD, RELOAD);
    do_round(RELOAD, DUCK);
    check("t4_sat_p", int'(p_count), 3);
    check("t4_sat_c", int'(c_count), 3);

    // 5: new_game beats choice_valid; async reset in hold
    pulse_new_game();
    do_round(DUCK, DUCK);
    wait_ready();
    new_game = 1; choice_valid = 1; p_choice = RELOAD; c_choice = RELOAD;
    @(negedge clk);
    new_game = 0; choice_valid = 0;
    check("t5_ng_round", int'(round_num), 0);
    check("t5_ng_p", int'(p_count), 1);
    @(negedge clk);
    check("t5_dropped_ready", int'(ready), 1);
    check("t5_dropped_rv", int'(result_valid), 0);
    do_round(RELOAD, DUCK);
    check("t5_pre_rst_round", int'(round_num), 1);
    #3 rst = 1;
    #1;
    check("t5_async_ready", int'(ready), 1);
    check("t5_async_round", int'(round_num), 0);
    check("t5_async_p", int'(p_count), 1);
    @(negedge clk);
    rst = 0;

    // 6: round limit
    pulse_new_game();
    for (int i = 0; i < 3; i++) do_round(DUCK, DUCK);
    check("t6_round", int'(round_num), 3);
`ifdef ROUND_LIMIT_EN
    check("t6_draw", int'(outcome), 3);
    check("t6_over", int'(game_over), 1);
`else
    check("t6_no_limit_out", int'(outcome), 0);
    check("t6_no_limit_go", int'(game_over), 0);
    wait_ready();
    check("t6_continues", int'(ready), 1);
`endif

    // random traffic against the model
    pulse_new_game();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      new_game     = ($urandom_range(0, 99) < 3);
      choice_valid = 1'($urandom_range(0, 1));
      p_choice     = pick();
      c_choice     = pick();
    end
    @(negedge clk);
    new_game = 0; choice_valid = 0;
    repeat (2) @(negedge clk);
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
